// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the arbiter, and the shared ALU.
// slave = arbiter view; master = requesters plus ALU view.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int SH_W   = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_srca;
  logic [DATA_W-1:0] req0_srcb;
  logic [SH_W-1:0]   req0_shamt;
  logic [OP_W-1:0]   req0_alu_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_srca;
  logic [DATA_W-1:0] req1_srcb;
  logic [SH_W-1:0]   req1_shamt;
  logic [OP_W-1:0]   req1_alu_op;

  logic [DATA_W-1:0] alu_srca;
  logic [DATA_W-1:0] alu_srcb;
  logic [SH_W-1:0]   alu_shamt;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_overflow;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_overflow;

  modport slave (
    input  req0_valid, req0_srca, req0_srcb, req0_shamt, req0_alu_op,
    output req0_ready,
    input  req1_valid, req1_srca, req1_srcb, req1_shamt, req1_alu_op,
    output req1_ready,
    output alu_srca, alu_srcb, alu_shamt, alu_op,
    input  alu_result, alu_overflow,
    output rsp0_valid, rsp0_result, rsp0_overflow,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_overflow,
    input  rsp1_ready
  );

  modport master (
    output req0_valid, req0_srca, req0_srcb, req0_shamt, req0_alu_op,
    input  req0_ready,
    output req1_valid, req1_srca, req1_srcb, req1_shamt, req1_alu_op,
    input  req1_ready,
    input  alu_srca, alu_srcb, alu_shamt, alu_op,
    output alu_result, alu_overflow,
    input  rsp0_valid, rsp0_result, rsp0_overflow,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_overflow,
    output rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a single registered response slot returned to the granted requester.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  alu_arbiter_if.slave io_bus
);

  logic              r_slot_valid;
  logic              r_slot_owner;
  logic [DATA_W-1:0] r_slot_result;
  logic              r_slot_ovf;
  logic              r_rr_ptr;

  logic w_owner_ready;
  logic w_can_accept;
  logic w_gnt_any;
  logic w_gnt_id;
  logic w_sel1;

  assign w_owner_ready = r_slot_owner ? io_bus.rsp1_ready : io_bus.rsp0_ready;
  // Drain and refill in the same cycle keeps throughput at one op per cycle.
  assign w_can_accept  = ~i_reset & (~r_slot_valid | w_owner_ready);

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = 1'b0;
    if (w_can_accept) begin
      if (io_bus.req0_valid & io_bus.req1_valid) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = r_rr_ptr;
      end else if (io_bus.req0_valid) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = 1'b0;
      end else if (io_bus.req1_valid) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = 1'b1;
      end
    end
  end

  assign io_bus.req0_ready = w_gnt_any & ~w_gnt_id;
  assign io_bus.req1_ready = w_gnt_any &  w_gnt_id;

  // Idle ALU inputs follow requester 0 so they are never undriven.
  assign w_sel1           = w_gnt_any & w_gnt_id;
  assign io_bus.alu_srca  = w_sel1 ? io_bus.req1_srca   : io_bus.req0_srca;
  assign io_bus.alu_srcb  = w_sel1 ? io_bus.req1_srcb   : io_bus.req0_srcb;
  assign io_bus.alu_shamt = w_sel1 ? io_bus.req1_shamt  : io_bus.req0_shamt;
  assign io_bus.alu_op    = w_sel1 ? io_bus.req1_alu_op : io_bus.req0_alu_op;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_slot_valid  <= 1'b0;
      r_slot_owner  <= 1'b0;
      r_slot_result <= '0;
      r_slot_ovf    <= 1'b0;
      r_rr_ptr      <= 1'b0;
    end else if (w_gnt_any) begin
      r_slot_valid  <= 1'b1;
      r_slot_owner  <= w_gnt_id;
      r_slot_result <= io_bus.alu_result;
      r_slot_ovf    <= io_bus.alu_overflow;
      r_rr_ptr      <= ~w_gnt_id;
    end else if (r_slot_valid & w_owner_ready) begin
      r_slot_valid  <= 1'b0;
    end
  end

  assign io_bus.rsp0_valid    = r_slot_valid & ~r_slot_owner;
  assign io_bus.rsp1_valid    = r_slot_valid &  r_slot_owner;
  assign io_bus.rsp0_result   = r_slot_result;
  assign io_bus.rsp1_result   = r_slot_result;
  assign io_bus.rsp0_overflow = r_slot_ovf;
  assign io_bus.rsp1_overflow = r_slot_ovf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in, slot/round-robin reference
// model, directed scenarios followed by constrained-random traffic.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(32), .OP_W(5), .SH_W(5)) bus ();
  alu_arbiter #(.DATA_W(32)) dut (.i_clk(clk), .i_reset(rst), .io_bus(bus));

  function automatic logic [32:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    logic        v;
    r = 32'habcddcba;
    v = 1'b0;
    case (op)
      5'd0:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd1:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << sh;
      5'd6:  r = a >> sh;
      5'd13: r = {31'd0, ($signed(a) < $signed(b))};
      default: ;
    endcase
    return {v, r};
  endfunction

  always_comb {bus.alu_overflow, bus.alu_result} =
    alu_ref(bus.alu_op, bus.alu_srca, bus.alu_srcb, bus.alu_shamt);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus per requester
  logic        v[2];
  logic [31:0] a[2];
  logic [31:0] b[2];
  logic [4:0]  sh[2];
  logic [4:0]  op[2];
  logic        rr[2];
  logic        acc[2];

  // Reference: the pending response and which requester is preferred on a tie
  logic        m_valid;
  logic        m_owner;
  logic [31:0] m_res;
  logic        m_ovf;
  logic        m_pref;

  task automatic m_reset();
    m_valid = 1'b0;
    m_owner = 1'b0;
    m_res   = '0;
    m_ovf   = 1'b0;
    m_pref  = 1'b0;
  endtask

  task automatic drive();
    bus.req0_valid  = v[0];
    bus.req0_srca   = a[0];
    bus.req0_srcb   = b[0];
    bus.req0_shamt  = sh[0];
    bus.req0_alu_op = op[0];
    bus.req1_valid  = v[1];
    bus.req1_srca   = a[1];
    bus.req1_srcb   = b[1];
    bus.req1_shamt  = sh[1];
    bus.req1_alu_op = op[1];
    bus.rsp0_ready  = rr[0];
    bus.rsp1_ready  = rr[1];
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    logic        free;
    int          win;
    int          sel;
    logic [32:0] r;
    drive();
    #1;
    free = !m_valid || rr[m_owner];
    win  = -1;
    if (free) begin
      if (v[0] && v[1]) win = m_pref ? 1 : 0;
      else if (v[0])    win = 0;
      else if (v[1])    win = 1;
    end
    sel = (win == 1) ? 1 : 0;
    chk("req0_ready", bus.req0_ready, win == 0);
    chk("req1_ready", bus.req1_ready, win == 1);
    chk("alu_operands", {bus.alu_srca, bus.alu_srcb}, {a[sel], b[sel]});
    chk("alu_ctl", {bus.alu_shamt, bus.alu_op}, {sh[sel], op[sel]});
    acc[0] = v[0] & bus.req0_ready;
    acc[1] = v[1] & bus.req1_ready;
    if (win >= 0) begin
      r       = alu_ref(op[sel], a[sel], b[sel], sh[sel]);
      m_valid = 1'b1;
      m_owner = sel[0];
      m_res   = r[31:0];
      m_ovf   = r[32];
      m_pref  = (win == 0);
    end else if (m_valid && rr[m_owner]) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk("rsp0_valid", bus.rsp0_valid, m_valid && !m_owner);
    chk("rsp1_valid", bus.rsp1_valid, m_valid && m_owner);
    chk("rsp_result", {bus.rsp0_result, bus.rsp1_result}, {m_res, m_res});
    chk("rsp_ovf", {bus.rsp0_overflow, bus.rsp1_overflow}, {m_ovf, m_ovf});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h7fffffff;
      2:       return 32'h80000000;
      3:       return 32'hffffffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int p = 0; p < 2; p++) begin
      v[p] = 0; a[p] = 0; b[p] = 0; sh[p] = 0; op[p] = 0; rr[p] = 1; acc[p] = 0;
    end
    m_reset();
    rst = 1'b1;
    v[0] = 1'b1;
    v[1] = 1'b1;
    drive();
    repeat (2) @(negedge clk);
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    chk("rst_result", bus.rsp0_result, 32'h0);
    rst = 1'b0;

    // Contention: alternating grants starting with requester 0
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_alternate", {acc[1], acc[0]}, (k % 2) ? 2'b10 : 2'b01);
      for (int p = 0; p < 2; p++)
        if (acc[p]) begin a[p] = $urandom; b[p] = $urandom; end
    end
    v[0] = 0; v[1] = 0;
    step();

    // Single subtract
    v[0] = 1; op[0] = 5'b00001; a[0] = 5; b[0] = 3;
    step();
    chk("single_acc", acc[0], 1'b1);
    chk("single_res", {bus.rsp0_valid, bus.rsp0_overflow, bus.rsp0_result}, {2'b10, 32'd2});
    v[0] = 0;
    step();

    // Overflow pass-through and signed compare
    v[1] = 1; op[1] = 5'b00000; a[1] = 32'h7fffffff; b[1] = 32'd1;
    step();
    chk("ovf_add", {bus.rsp1_overflow, bus.rsp1_result}, {1'b1, 32'h80000000});
    op[1] = 5'b01101; a[1] = 32'hffffffff; b[1] = 32'd0;
    step();
    chk("slt_neg", {bus.rsp1_overflow, bus.rsp1_result}, {1'b0, 32'h1});
    v[1] = 0;
    step();

    // Undefined opcode
    v[0] = 1; op[0] = 5'b11111; a[0] = $urandom; b[0] = $urandom;
    step();
    chk("undef_op", {bus.rsp0_overflow, bus.rsp0_result}, {1'b0, 32'habcddcba});
    v[0] = 0;
    step();

    // Backpressure on requester 0 blocks requester 1
    rr[0] = 0; v[0] = 1; op[0] = 5'b00000; a[0] = 100; b[0] = 23;
    step();
    v[0] = 0; v[1] = 1; op[1] = 5'b00001; a[1] = 50; b[1] = 8; rr[1] = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_block", acc[1], 1'b0);
      chk("bp_hold", {bus.rsp0_valid, bus.rsp0_result}, {1'b1, 32'd123});
    end
    rr[0] = 1;
    step();
    chk("bp_release", acc[1], 1'b1);
    chk("bp_rsp1", {bus.rsp1_valid, bus.rsp1_result}, {1'b1, 32'd42});
    v[1] = 0;
    step();

    // Reset while a response is held: valid drops at once, tie goes to 0 after
    rr[0] = 0; v[0] = 1; op[0] = 5'd2; a[0] = $urandom; b[0] = $urandom;
    step();
    rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.rsp0_valid, 1'b0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    v[0] = 1; v[1] = 1; rr[0] = 1; rr[1] = 1; a[0] = $urandom; a[1] = $urandom;
    step();
    chk("rst_rr_ptr", {acc[1], acc[0]}, 2'b01);
    v[0] = 0; v[1] = 0;
    step();

    rr[0] = 0; v[0] = 1;
    step();
    rst = 1'b1;
    #1;
    chk("rst_async_valid2", bus.rsp0_valid, 1'b0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    v[0] = 0; v[1] = 1; rr[0] = 1;
    step();
    chk("rst_lone_req1", acc[1], 1'b1);
    v[1] = 0;
    step();

    // Random traffic; a requester holds its op until it is accepted
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(v[p] && !acc[p])) begin
          v[p]  = ($urandom_range(0, 99) < 60);
          a[p]  = pick_operand();
          b[p]  = pick_operand();
          sh[p] = 5'($urandom);
          op[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
        end
        rr[p] = ($urandom_range(0, 99) < 70);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
